nic_fifo: RTL and testbench
===========================

NIC_FIFO -- requirements
Module: nic_fifo

Interface
REQ-001 SHALL have parameter DATA_W, default 64: data path width; DATA_W-1 is the virtual-channel bit.
REQ-002 SHALL have parameter OUT_DEPTH, default 4: output FIFO entries; power of two, 2..16.
REQ-003 SHALL have parameter IN_DEPTH, default 4: input FIFO entries; power of two, 2..16.
REQ-004 SHALL have port clk, input, 1: clock, all state updates on its rising edge.
REQ-005 SHALL have port reset, input, 1: synchronous, active-high reset.
REQ-006 SHALL have port d_in, input, DATA_W: processor write data.
REQ-007 SHALL have port nic_en, input, 1: processor access enable.
REQ-008 SHALL have port nic_wr_en, input, 1: 1 = write, 0 = read.
REQ-009 SHALL have port addr, input, 2: register select.
REQ-010 SHALL have port d_out, output, DATA_W: processor read data, combinational.
REQ-011 SHALL have port net_do, output, DATA_W: output FIFO head to router.
REQ-012 SHALL have port net_so, output, 1: send strobe to router.
REQ-013 SHALL have port net_ro, input, 1: router ready.
REQ-014 SHALL have port net_polarity, input, 1: current router phase.
REQ-015 SHALL have port net_di, input, DATA_W: data from router.
REQ-016 SHALL have port net_si, input, 1: router send strobe into NIC.
REQ-017 SHALL have port net_ri, output, 1: NIC ready to accept from router.

Function
REQ-018 SHALL decode processor write push as wr = nic_en & nic_wr_en & addr==2'b10.
REQ-019 SHALL decode processor read pop as rd = nic_en & ~nic_wr_en & addr==2'b00.
REQ-020 SHALL drive net_do = output FIFO head when out_count>0, else 0.
REQ-021 SHALL drive net_so = (out_count>0) & net_ro & (net_do[DATA_W-1] != net_polarity); pop the head on the same edge.
REQ-022 SHALL push d_in on wr when out_count<OUT_DEPTH, or when full and net_so=1 in the same cycle; count then stays OUT_DEPTH.
REQ-023 SHALL, on wr while full with net_so=0, discard d_in and set the sticky flag ovf.
REQ-024 SHALL drive net_ri = (in_count<IN_DEPTH); push net_di on net_si only when net_ri=1, else ignore net_si.
REQ-025 SHALL pop the input FIFO on rd when in_count>0; rd on empty is a no-op.
REQ-026 SHALL allow simultaneous push and pop on either FIFO: count unchanged, order preserved.
REQ-027 SHALL wrap read/write pointers modulo depth; counts are log2(depth)+1 bits.
REQ-028 SHALL drive d_out by addr: 00 = input head (0 if empty); 01 = {0, in_full, in_count>0}; 10 = {0, in_count[7:0], out_count[7:0]}; 11 = {0, ovf, out_count==OUT_DEPTH}.
REQ-029 SHALL clear ovf on a read at addr 11 (nic_en & ~nic_wr_en); a same-cycle set takes priority.

Reset
REQ-030 SHALL, while reset=1, clear pointers, counts, ovf (and irq when compiled in); net_so=0, net_ri=1, net_do=0 next cycle.
REQ-031 SHALL discard any FIFO contents and in-flight push/pop when reset asserts mid-operation; storage contents need not be cleared.

Configuration
REQ-032 SHALL, with macro NIC_FIFO_IRQ_EN defined, add output irq (1 bit, registered) = (in_count>0) | ovf, updated each edge.
REQ-033 SHALL, with NIC_FIFO_IRQ_EN undefined, omit the irq port and its register; all other behaviour identical.

Verification
REQ-034 SHALL cover: reset, then write 0x1 at addr 10 with net_ro=1, net_polarity=1 -> net_so=1 the following cycle, net_do=0x1, out_count back to 0.
REQ-035 SHALL cover: write 0x8000_0000_0000_0005 (VC bit 1), net_polarity=1, net_ro=1 -> net_so=0 until polarity toggles to 0, then one-cycle net_so.
REQ-036 SHALL cover: net_ro=0, 5 writes 0xA..0xE at depth 4 -> addr 11 reads 0b11; entries 0xA..0xD drain in order; read at 11 clears ovf -> 0b00 when empty.
REQ-037 SHALL cover: 4 router pushes 0x10..0x13 -> net_ri=0 after the 4th; 5th net_si ignored; addr 00 reads return 0x10..0x13 in order, then 0.
REQ-038 SHALL cover: input full, rd and net_si same cycle -> net_si ignored (net_ri=0), in_count 4->3, net_ri=1 next cycle.
REQ-039 SHALL cover: reset asserted with out_count=3, in_count=2 -> next cycle counts 0, net_so=0, net_ri=1, irq=0 when NIC_FIFO_IRQ_EN defined.

Source files
------------

// File: rtl/nic_fifo.sv
// nic_fifo: processor<->router NIC with output FIFO (to router) and input FIFO (from router).
// Optional registered irq output when NIC_FIFO_IRQ_EN is defined.
module nic_fifo #(
    parameter int DATA_W    = 64,
    parameter int OUT_DEPTH = 4,
    parameter int IN_DEPTH  = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] d_in,
    input  logic              nic_en,
    input  logic              nic_wr_en,
    input  logic [1:0]        addr,
    output logic [DATA_W-1:0] d_out,
    output logic [DATA_W-1:0] net_do,
    output logic              net_so,
    input  logic              net_ro,
    input  logic              net_polarity,
    input  logic [DATA_W-1:0] net_di,
    input  logic              net_si,
    output logic              net_ri
`ifdef NIC_FIFO_IRQ_EN
    ,
    output logic              irq
`endif
);
    localparam int OAW = $clog2(OUT_DEPTH);
    localparam int IAW = $clog2(IN_DEPTH);
    localparam logic [OAW:0] OFULL = (OAW+1)'(OUT_DEPTH);
    localparam logic [IAW:0] IFULL = (IAW+1)'(IN_DEPTH);

    logic [DATA_W-1:0] out_mem [OUT_DEPTH];
    logic [DATA_W-1:0] in_mem  [IN_DEPTH];
    logic [OAW-1:0]    out_wp_q, out_wp_d, out_rp_q, out_rp_d;
    logic [OAW:0]      out_cnt_q, out_cnt_d;
    logic [IAW-1:0]    in_wp_q, in_wp_d, in_rp_q, in_rp_d;
    logic [IAW:0]      in_cnt_q, in_cnt_d;
    logic              ovf_q, ovf_d;
    logic              wr, rd, ovf_clr, ovf_set;
    logic              out_ne, out_full, in_ne, in_full;
    logic              out_push, out_pop, in_push, in_pop;

    assign wr       = nic_en & nic_wr_en & (addr == 2'b10);
    assign rd       = nic_en & ~nic_wr_en & (addr == 2'b00);
    assign ovf_clr  = nic_en & ~nic_wr_en & (addr == 2'b11);
    assign out_ne   = out_cnt_q != '0;
    assign out_full = out_cnt_q == OFULL;
    assign in_ne    = in_cnt_q != '0;
    assign in_full  = in_cnt_q == IFULL;

    assign net_do   = out_ne ? out_mem[out_rp_q] : '0;
    assign net_so   = out_ne & net_ro & (net_do[DATA_W-1] != net_polarity);
    assign net_ri   = ~in_full;

    // A full output FIFO still accepts a write when the head leaves on the same edge
    assign out_pop  = net_so;
    assign out_push = wr & (~out_full | net_so);
    assign ovf_set  = wr & out_full & ~net_so;
    assign in_push  = net_si & net_ri;
    assign in_pop   = rd & in_ne;

    assign d_out = addr == 2'b00 ? (in_ne ? in_mem[in_rp_q] : '0) :
                   addr == 2'b01 ? DATA_W'({in_full, in_ne}) :
                   addr == 2'b10 ? DATA_W'({8'(in_cnt_q), 8'(out_cnt_q)}) :
                                   DATA_W'({ovf_q, out_full});

    always_comb begin
        out_wp_d  = out_push ? out_wp_q + OAW'(1) : out_wp_q;
        out_rp_d  = out_pop ? out_rp_q + OAW'(1) : out_rp_q;
        out_cnt_d = out_cnt_q + (OAW+1)'(out_push) - (OAW+1)'(out_pop);
        in_wp_d   = in_push ? in_wp_q + IAW'(1) : in_wp_q;
        in_rp_d   = in_pop ? in_rp_q + IAW'(1) : in_rp_q;
        in_cnt_d  = in_cnt_q + (IAW+1)'(in_push) - (IAW+1)'(in_pop);
        ovf_d     = ovf_set ? 1'b1 : ovf_clr ? 1'b0 : ovf_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            out_wp_q  <= '0;
            out_rp_q  <= '0;
            out_cnt_q <= '0;
            in_wp_q   <= '0;
            in_rp_q   <= '0;
            in_cnt_q  <= '0;
            ovf_q     <= 1'b0;
        end else begin
            out_wp_q  <= out_wp_d;
            out_rp_q  <= out_rp_d;
            out_cnt_q <= out_cnt_d;
            in_wp_q   <= in_wp_d;
            in_rp_q   <= in_rp_d;
            in_cnt_q  <= in_cnt_d;
            ovf_q     <= ovf_d;
        end
    end

    // Storage is never cleared; the counts alone define what is valid
    always_ff @(posedge clk) begin
        if (!reset && out_push) out_mem[out_wp_q] <= d_in;
        if (!reset && in_push) in_mem[in_wp_q] <= net_di;
    end

`ifdef NIC_FIFO_IRQ_EN
    logic irq_q;
    always_ff @(posedge clk) begin
        if (reset) irq_q <= 1'b0;
        else irq_q <= (in_cnt_d != '0) | ovf_d;
    end
    assign irq = irq_q;
`endif
endmodule

// File: tb/tb_nic_fifo.sv
// tb_nic_fifo: directed self-checking bench for nic_fifo (default build, depth 4, 64-bit).
module tb_nic_fifo;
    logic        clk = 1'b0;
    logic        reset, nic_en, nic_wr_en, net_ro, net_polarity, net_si;
    logic [1:0]  addr;
    logic [63:0] d_in, net_di, d_out, net_do, v;
    logic        net_so, net_ri;
    int          n_cmp = 0;
    int          n_fail = 0;

    nic_fifo dut (
        .clk(clk), .reset(reset), .d_in(d_in), .nic_en(nic_en), .nic_wr_en(nic_wr_en),
        .addr(addr), .d_out(d_out), .net_do(net_do), .net_so(net_so), .net_ro(net_ro),
        .net_polarity(net_polarity), .net_di(net_di), .net_si(net_si), .net_ri(net_ri)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic peek(input logic [1:0] a, output logic [63:0] r);
        nic_en = 1'b0;
        addr = a;
        #1;
        r = d_out;
    endtask

    task automatic wr_out(input logic [63:0] data);
        nic_en = 1'b1; nic_wr_en = 1'b1; addr = 2'b10; d_in = data;
        tick();
        nic_en = 1'b0; nic_wr_en = 1'b0;
    endtask

    task automatic push_in(input logic [63:0] data);
        net_si = 1'b1; net_di = data;
        tick();
        net_si = 1'b0;
    endtask

    task automatic rd_in();
        nic_en = 1'b1; nic_wr_en = 1'b0; addr = 2'b00;
        tick();
        nic_en = 1'b0;
    endtask

    initial begin
        reset = 1'b1; nic_en = 1'b0; nic_wr_en = 1'b0; addr = 2'b00; d_in = '0;
        net_ro = 1'b0; net_polarity = 1'b0; net_di = '0; net_si = 1'b0;
        tick(); tick();
        reset = 1'b0;
        #1;
        chk("rst_so", 64'(net_so), 64'd0);
        chk("rst_ri", 64'(net_ri), 64'd1);
        chk("rst_do", net_do, 64'd0);
        peek(2'b10, v); chk("rst_cnt", v, 64'd0);
        peek(2'b11, v); chk("rst_ovf", v, 64'd0);
        peek(2'b01, v); chk("rst_stat", v, 64'd0);
        peek(2'b00, v); chk("rst_head", v, 64'd0);

        // single word straight through
        net_ro = 1'b1; net_polarity = 1'b1;
        wr_out(64'h1);
        chk("w1_so", 64'(net_so), 64'd1);
        chk("w1_do", net_do, 64'h1);
        tick();
        chk("w1_so_after", 64'(net_so), 64'd0);
        chk("w1_do_after", net_do, 64'd0);
        peek(2'b10, v); chk("w1_cnt", v, 64'd0);

        // VC bit equal to polarity holds the head until the phase changes
        wr_out(64'h8000_0000_0000_0005);
        chk("vc_so_hold", 64'(net_so), 64'd0);
        chk("vc_do", net_do, 64'h8000_0000_0000_0005);
        tick();
        chk("vc_so_hold2", 64'(net_so), 64'd0);
        net_polarity = 1'b0;
        #1;
        chk("vc_so_go", 64'(net_so), 64'd1);
        tick();
        chk("vc_so_done", 64'(net_so), 64'd0);
        peek(2'b10, v); chk("vc_cnt", v, 64'd0);

        // overflow: five writes into a depth-4 FIFO with the router stalled
        net_ro = 1'b0;
        for (int i = 0; i < 5; i++) wr_out(64'hA + 64'(i));
        peek(2'b11, v); chk("ovf_flags", v, 64'b11);
        peek(2'b10, v); chk("ovf_cnt", v, 64'h0004);
        net_ro = 1'b1; net_polarity = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("ovf_drain_so", 64'(net_so), 64'd1);
            chk("ovf_drain_do", net_do, 64'hA + 64'(i));
            tick();
        end
        chk("ovf_empty_so", 64'(net_so), 64'd0);
        chk("ovf_empty_do", net_do, 64'd0);
        peek(2'b11, v); chk("ovf_sticky", v, 64'b10);
        nic_en = 1'b1; nic_wr_en = 1'b0; addr = 2'b11;
        tick();
        peek(2'b11, v); chk("ovf_clr", v, 64'b00);

        // write into a full FIFO while the head leaves: accepted, no overflow
        net_ro = 1'b0;
        for (int i = 0; i < 4; i++) wr_out(64'h30 + 64'(i));
        net_ro = 1'b1;
        wr_out(64'h34);
        net_ro = 1'b0;
        peek(2'b11, v); chk("fullpass_flags", v, 64'b01);
        chk("fullpass_head", net_do, 64'h31);
        net_ro = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("fullpass_drain", net_do, 64'h31 + 64'(i));
            tick();
        end
        peek(2'b10, v); chk("fullpass_cnt", v, 64'd0);
        net_ro = 1'b0;

        // input FIFO fill, ignored fifth strobe, ordered reads
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("in_ri_before", 64'(net_ri), 64'd1);
            push_in(64'h10 + 64'(i));
        end
        chk("in_ri_full", 64'(net_ri), 64'd0);
        peek(2'b01, v); chk("in_stat", v, 64'b11);
        push_in(64'h99);
        peek(2'b10, v); chk("in_cnt_full", v, 64'h0400);
        for (int i = 0; i < 4; i++) begin
            peek(2'b00, v); chk("in_head", v, 64'h10 + 64'(i));
            rd_in();
        end
        peek(2'b00, v); chk("in_head_empty", v, 64'd0);
        rd_in();
        peek(2'b10, v); chk("in_rd_empty", v, 64'd0);

        // read and router strobe together on a full input FIFO
        for (int i = 0; i < 4; i++) push_in(64'h20 + 64'(i));
        nic_en = 1'b1; nic_wr_en = 1'b0; addr = 2'b00; net_si = 1'b1; net_di = 64'h77;
        tick();
        nic_en = 1'b0; net_si = 1'b0;
        chk("rdsi_ri", 64'(net_ri), 64'd1);
        peek(2'b10, v); chk("rdsi_cnt", v, 64'h0300);
        for (int i = 0; i < 3; i++) begin
            peek(2'b00, v); chk("rdsi_head", v, 64'h21 + 64'(i));
            rd_in();
        end
        peek(2'b10, v); chk("rdsi_cnt_end", v, 64'd0);

        // reset mid-operation
        for (int i = 0; i < 3; i++) wr_out(64'h40 + 64'(i));
        push_in(64'h50); push_in(64'h51);
        peek(2'b10, v); chk("prerst_cnt", v, 64'h0203);
        net_ro = 1'b1; net_polarity = 1'b1; reset = 1'b1;
        tick();
        chk("midrst_so", 64'(net_so), 64'd0);
        chk("midrst_ri", 64'(net_ri), 64'd1);
        chk("midrst_do", net_do, 64'd0);
        peek(2'b10, v); chk("midrst_cnt", v, 64'd0);
        reset = 1'b0;
        tick();
        peek(2'b11, v); chk("postrst_flags", v, 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
